// File: rtl/dcm_reset_sequencer.sv
// DCM reset sequencer: pulses the DCM reset, waits for a synchronized lock, then settles.
// After settling it releases the system reset; it retries on lock timeout and latches failure.
module dcm_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned SETTLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       SYSTEM_CLOCK,
  input  logic       reset,
  input  logic       dcm_locked,
  input  logic       relock_req,
  output logic       dcm_reset,
  output logic       sys_reset,
  output logic       lock_fail,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOSS_W  = 8;

  localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);
  localparam logic [LOSS_W-1:0]  LOSS_SAT     = '1;

  typedef enum logic [2:0] {
    RESET_DCM = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [LOSS_W-1:0]    loss_q, loss_d;
  logic                 fail_q, fail_d;
  logic                 dcm_reset_q, sys_reset_q;
  logic                 lock_meta_q, lock_sync_q;
  logic                 locked_s;
  logic [LOSS_W-1:0]    loss_inc;

  assign locked_s = lock_sync_q;
  assign loss_inc = (loss_q == LOSS_SAT) ? loss_q : loss_q + LOSS_W'(1);

  // Two-flop synchronizer for the asynchronous DCM lock status
  always_ff @(posedge SYSTEM_CLOCK or posedge reset) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= dcm_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  always_ff @(posedge SYSTEM_CLOCK or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_DCM;
      timer_q     <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      fail_q      <= 1'b0;
      dcm_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      fail_q      <= fail_d;
      dcm_reset_q <= (state_d == RESET_DCM);
      sys_reset_q <= (state_d != RUN);
    end
  end

  // Next state; relock_req overrides every other transition
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TIMER_W'(1);
    retry_d = retry_q;
    loss_d  = loss_q;
    fail_d  = fail_q;
    if (relock_req) begin
      state_d = RESET_DCM;
      retry_d = '0;
      fail_d  = 1'b0;
      if (state_q == RUN && !locked_s) begin
        loss_d = loss_inc;
      end
    end else begin
      unique case (state_q)
        RESET_DCM: begin
          if (timer_q == PULSE_LAST) begin
            state_d = WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = SETTLE;
          end else if (timer_q == TIMEOUT_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = RESET_DCM;
            end else begin
              state_d = FAIL;
              fail_d  = 1'b1;
            end
          end
        end
        SETTLE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (timer_q == SETTLE_LAST) begin
            state_d = RUN;
            retry_d = '0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_d = RESET_DCM;
            loss_d  = loss_inc;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = RESET_DCM;
        end
      endcase
    end
    // Timer restarts on any transition and idles at zero where it is unused
    if (relock_req || state_d != state_q || state_d == RUN || state_d == FAIL) begin
      timer_d = '0;
    end
  end

  assign dcm_reset       = dcm_reset_q;
  assign sys_reset       = sys_reset_q;
  assign lock_fail       = fail_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;
  assign state           = state_q;

endmodule

// File: doc/dcm_reset_sequencer.md
DCM_RESET_SEQUENCER -- requirements
Module: dcm_reset_sequencer

Interface
REQ-001 Parameter RST_PULSE_CYCLES, default 4, cycles dcm_reset is held high per DCM reset attempt (1..65535).
REQ-002 Parameter LOCK_TIMEOUT_CYCLES, default 50000, cycles allowed for synchronized lock after dcm_reset release (1..65535).
REQ-003 Parameter SETTLE_CYCLES, default 1024, consecutive synchronized-lock cycles required before sys_reset release (1..65535).
REQ-004 Parameter MAX_RETRIES, default 3, lock-timeout retries before FAIL (0..15).
REQ-005 SYSTEM_CLOCK  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high; one clock, no other clock domains.
REQ-007 dcm_locked  in  1  DCM LOCKED status, asynchronous to SYSTEM_CLOCK.
REQ-008 relock_req  in  1  single-cycle request to restart the DCM sequence.
REQ-009 dcm_reset  out  1  DCM RST drive, active-high.
REQ-010 sys_reset  out  1  downstream (pixel/system logic) reset, active-high.
REQ-011 lock_fail  out  1  sticky flag: retries exhausted.
REQ-012 retry_count  out  4  timeout retries used in the current sequence.
REQ-013 lock_loss_count  out  8  lock drops seen in RUN, saturating at 255.
REQ-014 state  out  3  encoded FSM state: RESET_DCM=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAIL=4.

Function
REQ-015 dcm_locked SHALL pass through a 2-flop synchronizer; "locked_s" below is the second flop's output (2-cycle latency).
REQ-016 All outputs SHALL be registered; one 16-bit timer SHALL be shared by all states and cleared on every state transition.
REQ-017 RESET_DCM: dcm_reset=1, sys_reset=1; after RST_PULSE_CYCLES cycles in state -> WAIT_LOCK.
REQ-018 WAIT_LOCK: dcm_reset=0, sys_reset=1; locked_s=1 -> SETTLE.
REQ-019 WAIT_LOCK: timer reaching LOCK_TIMEOUT_CYCLES-1 with locked_s=0 -> RESET_DCM with retry_count+1 if retry_count<MAX_RETRIES, else -> FAIL.
REQ-020 WAIT_LOCK: lock and timeout in the same cycle -> lock wins (SETTLE).
REQ-021 SETTLE: sys_reset=1; locked_s=0 at any point -> WAIT_LOCK with timeout timer restarted, retry_count unchanged.
REQ-022 SETTLE: SETTLE_CYCLES consecutive locked_s=1 cycles -> RUN; sys_reset falls on the cycle state becomes RUN.
REQ-023 RUN: dcm_reset=0, sys_reset=0, retry_count cleared to 0 on entry.
REQ-024 RUN: locked_s=0 -> RESET_DCM, sys_reset=1 on the next edge, lock_loss_count+1 (saturating at 255).
REQ-025 FAIL: dcm_reset=0, sys_reset=1, lock_fail=1; only relock_req exits (-> RESET_DCM).
REQ-026 relock_req in any state -> RESET_DCM, retry_count=0, lock_fail=0; it takes priority over all other transitions.
REQ-027 RUN with lock loss and relock_req in the same cycle -> RESET_DCM; lock_loss_count still increments.
REQ-028 sys_reset SHALL never be 0 outside RUN; dcm_reset SHALL be 1 only in RESET_DCM.

Reset
REQ-029 reset=1 SHALL immediately force: state=RESET_DCM, dcm_reset=1, sys_reset=1, lock_fail=0, retry_count=0, lock_loss_count=0, timer=0, synchronizer flops=0.
REQ-030 After reset deasserts, the full sequence (REQ-017) SHALL restart; reset mid-sequence aborts any state, including RUN and FAIL.

Verification (bench params: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=16, SETTLE_CYCLES=8, MAX_RETRIES=2)
REQ-031 Clean lock: release reset, raise dcm_locked 3 cycles after dcm_reset falls -> dcm_reset high exactly 4 cycles; sys_reset falls 2+8 cycles after the lock rise; state=3; retry_count=0.
REQ-032 No lock: hold dcm_locked=0 -> three 4-cycle dcm_reset pulses each followed by 16 WAIT_LOCK cycles; then state=4, lock_fail=1, retry_count=2, sys_reset=1; relock_req -> lock_fail=0, state=0.
REQ-033 Settle glitch: drop dcm_locked for 1 cycle at SETTLE cycle 5 -> return to WAIT_LOCK; sys_reset stays 1; RUN entered only after 8 fresh consecutive lock cycles.
REQ-034 Lock loss in RUN: drop dcm_locked -> 2 cycles later state=0, sys_reset=1, dcm_reset=1, lock_loss_count=1; repeat 300 times -> lock_loss_count=255.
REQ-035 Boundary: assert lock on WAIT_LOCK timer=15 -> SETTLE, not a retry; assert relock_req together with lock loss in RUN -> state=0, lock_loss_count increments once.
REQ-036 Async reset pulse mid-SETTLE (between clock edges) -> all outputs take reset values before the next edge; normal sequence repeats.
